// File: rtl/ecc_sed_arbiter.sv
// Two-requester round-robin arbiter feeding a single even-parity (SED) encoder
// register with zero-bubble valid/ready handoff and per-source delivery counters.
module ecc_sed_arbiter #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              enc_valid,
    input  logic              enc_ready,
    output logic [DATA_W:0]   enc_codeword,
    output logic              enc_src,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic              last_grant;
    logic              transfer;
    logic              can_accept;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              accept_src;
    logic [DATA_W-1:0] accept_data;

    assign transfer   = (state == FULL) && enc_ready;
    assign can_accept = !rst && ((state == EMPTY) || enc_ready);

    // last_grant == 1 means requester 0 has priority on a tie, and vice versa.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (can_accept) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign accept      = grant0 || grant1;
    assign accept_src  = grant1;
    assign accept_data = grant1 ? req1_data : req0_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            enc_valid    <= 1'b0;
            enc_codeword <= '0;
            enc_src      <= 1'b0;
            last_grant   <= 1'b1;
        end else begin
            if (accept) begin
                state        <= FULL;
                enc_valid    <= 1'b1;
                enc_codeword <= {^accept_data, accept_data};
                enc_src      <= accept_src;
                last_grant   <= accept_src;
            end else if (transfer) begin
                state     <= EMPTY;
                enc_valid <= 1'b0;
            end
        end
    end

    // Counters saturate; a clear wins over an increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (transfer) begin
            if (!enc_src && (cnt0 != CNT_MAX)) begin
                cnt0 <= cnt0 + 1'b1;
            end
            if (enc_src && (cnt1 != CNT_MAX)) begin
                cnt1 <= cnt1 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ecc_sed_arbiter.sv
// Directed bench for ecc_sed_arbiter: expected codewords go into a scoreboard
// queue at acceptance and a negedge monitor checks them as they are delivered.
module tb_ecc_sed_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [11:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [11:0] req1_data;
    logic        req1_ready;
    logic        enc_valid;
    logic        enc_ready;
    logic [12:0] enc_codeword;
    logic        enc_src;
    logic        cnt_clr;
    logic [1:0]  cnt0;
    logic [1:0]  cnt1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [13:0] sb_q[$];
    logic [13:0] sb_item;

    ecc_sed_arbiter #(
        .DATA_W(12),
        .CNT_W (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .enc_valid   (enc_valid),
        .enc_ready   (enc_ready),
        .enc_codeword(enc_codeword),
        .enc_src     (enc_src),
        .cnt_clr     (cnt_clr),
        .cnt0        (cnt0),
        .cnt1        (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every downstream transfer must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && enc_valid === 1'b1 && enc_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL sb_unexpected: got codeword 0x%0h src %0d expected no transfer",
                         enc_codeword, enc_src);
            end else begin
                sb_item = sb_q.pop_front();
                checkOutput("sb_codeword", 32'(enc_codeword), 32'(sb_item[12:0]));
                checkOutput("sb_src", 32'(enc_src), 32'(sb_item[13]));
            end
        end
    end

    // Called at posedge+1; drives one cycle of inputs and returns at the next posedge+1.
    task automatic applyStimulus(input logic v0, input logic [11:0] d0,
                                 input logic v1, input logic [11:0] d1,
                                 input logic er, input logic clr,
                                 input logic exp_r0, input logic exp_r1,
                                 input logic [12:0] exp_cw);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        enc_ready  = er;
        cnt_clr    = clr;
        #1;
        checkOutput("req0_ready", 32'(req0_ready), 32'(exp_r0));
        checkOutput("req1_ready", 32'(req1_ready), 32'(exp_r1));
        if (exp_r0 || exp_r1) sb_q.push_back({exp_r1, exp_cw});
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset(input logic er);
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 12'h00F;
        req1_valid = 1'b1;
        req1_data  = 12'h0F0;
        enc_ready  = er;
        cnt_clr    = 1'b0;
        #1;
        checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
        checkOutput("rst_req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_enc_valid", 32'(enc_valid), 32'd0);
        checkOutput("rst_enc_codeword", 32'(enc_codeword), 32'd0);
        checkOutput("rst_enc_src", 32'(enc_src), 32'd0);
        checkOutput("rst_cnt0", 32'(cnt0), 32'd0);
        checkOutput("rst_cnt1", 32'(cnt1), 32'd0);
        sb_q.delete();
        rst        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        enc_ready  = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_data  = '0;
        enc_ready  = 1'b1;
        cnt_clr    = 1'b0;
        @(posedge clk);
        #1;
        applyReset(1'b1);

        // Single word from requester 0, latency 1, then delivered.
        applyStimulus(1, 12'h001, 0, 12'h000, 1, 0, 1, 0, 13'h1001);
        applyStimulus(0, 12'h000, 0, 12'h000, 1, 0, 0, 0, 13'h0000);
        checkOutput("cnt0_after_first", 32'(cnt0), 32'd1);
        checkOutput("cnt1_after_first", 32'(cnt1), 32'd0);

        // Both requesters valid every cycle: strict alternation starting with 0.
        applyReset(1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 12'h0FF, 1, 12'h003, 1, 0, 1, 0, 13'h00FF);
            applyStimulus(1, 12'h0FF, 1, 12'h003, 1, 0, 0, 1, 13'h0003);
        end
        applyStimulus(0, 12'h000, 0, 12'h000, 1, 0, 0, 0, 13'h0000);
        checkOutput("cnt0_alternate", 32'(cnt0), 32'd2);
        checkOutput("cnt1_alternate", 32'(cnt1), 32'd2);

        // Backpressure: word held stable five cycles, then zero-bubble handoff.
        applyStimulus(1, 12'h0A5, 0, 12'h000, 0, 0, 1, 0, 13'h00A5);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 12'h0A5, 1, 12'h001, 0, 0, 0, 0, 13'h0000);
            checkOutput("hold_enc_valid", 32'(enc_valid), 32'd1);
            checkOutput("hold_codeword", 32'(enc_codeword), 32'h00A5);
            checkOutput("hold_src", 32'(enc_src), 32'd0);
        end
        applyStimulus(1, 12'h0A5, 1, 12'h001, 1, 0, 0, 1, 13'h1001);
        applyStimulus(0, 12'h000, 0, 12'h000, 1, 0, 0, 0, 13'h0000);
        checkOutput("cnt0_after_hold", 32'(cnt0), 32'd3);
        checkOutput("cnt1_after_hold", 32'(cnt1), 32'd3);

        // Five transfers from source 0 saturate a 2-bit counter; parity corner words.
        applyReset(1'b1);
        applyStimulus(1, 12'hFFF, 0, 12'h000, 1, 0, 1, 0, 13'h0FFF);
        applyStimulus(1, 12'h800, 0, 12'h000, 1, 0, 1, 0, 13'h1800);
        applyStimulus(1, 12'hFFF, 0, 12'h000, 1, 0, 1, 0, 13'h0FFF);
        checkOutput("cnt0_midway", 32'(cnt0), 32'd2);
        applyStimulus(1, 12'h800, 0, 12'h000, 1, 0, 1, 0, 13'h1800);
        applyStimulus(1, 12'hFFF, 0, 12'h000, 1, 0, 1, 0, 13'h0FFF);
        applyStimulus(0, 12'h000, 0, 12'h000, 1, 0, 0, 0, 13'h0000);
        checkOutput("cnt0_saturated", 32'(cnt0), 32'd3);
        checkOutput("cnt1_untouched", 32'(cnt1), 32'd0);

        // Clear coincides with a transfer: clear wins.
        applyStimulus(1, 12'h001, 0, 12'h000, 1, 0, 1, 0, 13'h1001);
        applyStimulus(0, 12'h000, 0, 12'h000, 1, 1, 0, 0, 13'h0000);
        checkOutput("cnt0_cleared", 32'(cnt0), 32'd0);
        checkOutput("cnt1_cleared", 32'(cnt1), 32'd0);

        // Reset while a word is held discards it and restores the tie pointer.
        applyStimulus(0, 12'h000, 1, 12'h003, 1, 0, 0, 1, 13'h0003);
        applyStimulus(1, 12'h002, 0, 12'h000, 1, 0, 1, 0, 13'h1002);
        applyStimulus(0, 12'h000, 0, 12'h000, 0, 0, 0, 0, 13'h0000);
        checkOutput("cnt1_before_reset", 32'(cnt1), 32'd1);
        checkOutput("held_codeword", 32'(enc_codeword), 32'h1002);
        applyReset(1'b0);
        applyStimulus(1, 12'h0FF, 1, 12'h003, 1, 0, 1, 0, 13'h00FF);
        applyStimulus(0, 12'h000, 0, 12'h000, 1, 0, 0, 0, 13'h0000);
        checkOutput("cnt0_after_reset", 32'(cnt0), 32'd1);
        checkOutput("cnt1_after_reset", 32'(cnt1), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_sed_arbiter.md
ECC_SED_ARBITER -- requirements
Module: ecc_sed_arbiter

Interface
REQ-001: The block SHALL have parameter DATA_W, default 12, data word width; codeword width is DATA_W+1.
REQ-002: The block SHALL have parameter CNT_W, default 8, width of the per-source issue counters.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: req0_valid  input  1  requester 0 presents a data word.
REQ-006: req0_data  input  DATA_W  requester 0 data word.
REQ-007: req0_ready  output  1  requester 0 word accepted this cycle.
REQ-008: req1_valid  input  1  requester 1 presents a data word.
REQ-009: req1_data  input  DATA_W  requester 1 data word.
REQ-010: req1_ready  output  1  requester 1 word accepted this cycle.
REQ-011: enc_valid  output  1  enc_codeword/enc_src hold a valid codeword.
REQ-012: enc_ready  input  1  downstream consumer accepts the codeword.
REQ-013: enc_codeword  output  DATA_W+1  {parity, data}.
REQ-014: enc_src  output  1  source index (0/1) of the current codeword.
REQ-015: cnt_clr  input  1  synchronous clear of both issue counters.
REQ-016: cnt0, cnt1  output  CNT_W each  codewords delivered downstream per source.

Function
REQ-017: Parity SHALL be even: enc_codeword[DATA_W] = XOR of all data bits; enc_codeword[DATA_W-1:0] = accepted data unmodified.
REQ-018: The block SHALL hold one output register with states EMPTY (enc_valid=0) and FULL (enc_valid=1).
REQ-019: Transfer downstream SHALL occur on a cycle with enc_valid=1 and enc_ready=1.
REQ-020: The block SHALL accept a request when the register is EMPTY, or FULL and transferring in the same cycle (zero-bubble throughput, one word per cycle).
REQ-021: Arbitration SHALL be round-robin: one valid requester wins; both valid, the source not granted last wins.
REQ-022: At most one of req0_ready/req1_ready SHALL be high per cycle; readies SHALL be combinational from valids, register state, enc_ready and the last-grant pointer.
REQ-023: A ready SHALL only assert while its own valid is high; an accepted word SHALL appear on enc_codeword one cycle later (latency 1).
REQ-024: The last-grant pointer SHALL update only on an acceptance, to the accepted source.
REQ-025: While FULL and enc_ready=0, enc_codeword, enc_src and enc_valid SHALL stay stable and no request SHALL be accepted.
REQ-026: FULL with transfer and no acceptance SHALL go EMPTY; EMPTY with acceptance SHALL go FULL.
REQ-027: cnt[enc_src] SHALL increment by 1 on each downstream transfer and saturate at 2^CNT_W-1.
REQ-028: cnt_clr SHALL zero both counters and take priority over a simultaneous increment.

Reset
REQ-029: During rst: enc_valid=0, enc_codeword=0, enc_src=0, cnt0=cnt1=0, req0_ready=req1_ready=0, pointer=1 (requester 0 wins first tie).
REQ-030: Reset mid-operation SHALL discard any held codeword without transfer and without counter update.

Verification
REQ-031: Reset, req0_valid=1 data=0x001, enc_ready=1 -> req0_ready=1; next cycle enc_valid=1, enc_codeword=0x1001, enc_src=0.
REQ-032: Both valid every cycle, data0=0x0FF, data1=0x003, enc_ready=1 -> grants alternate 0,1,0,1; codewords 0x00FF, 0x0003 alternate; one per cycle.
REQ-033: Word held with enc_ready=0 for 5 cycles -> codeword stable, both readies 0; on enc_ready=1 transfer and same-cycle acceptance of next word.
REQ-034: CNT_W=2, 5 transfers from source 0 -> cnt0=3 saturated; cnt_clr with a transfer in the same cycle -> cnt0=0.
REQ-035: rst asserted while FULL with enc_ready=0 -> next cycle enc_valid=0, counters 0; first tie afterwards grants requester 0.
REQ-036: data=0xFFF -> parity 0, codeword 0x0FFF; data=0x800 -> codeword 0x1800.
